// File: rtl/mem_port_arbiter_pkg.sv
// Shared processor package for the memory port arbiter.
// Holds the default bus widths, the return-tag encoding used to steer read
// data back to the winning requester, and the starvation counter width.
package mem_port_arbiter_pkg;

  localparam int PKG_ADDR_W = 8;
  localparam int PKG_DATA_W = 8;
  localparam int STARVE_W   = 3;

  // Which side owns the byte coming back from the RAM this cycle.
  typedef enum logic [1:0] {
    RTAG_NONE  = 2'b00,
    RTAG_FETCH = 2'b01,
    RTAG_DATA  = 2'b10
  } rtag_e;

  // Return tag plus a flag marking a data write, so a write completion
  // reports zero read data instead of whatever the RAM output holds.
  typedef struct packed {
    rtag_e tag;
    logic  wr;
  } ret_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single-port unified instruction/data RAM between the fetch
// stage and the memory stage. One requester wins each cycle; its request is
// driven onto the RAM combinationally and the returning byte is steered to
// it in the following cycle. A starvation counter forces fetch through after
// STARVE_MAX consecutive denials.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request and address
//   if_wait/if_rvalid/if_rdata       fetch stall, read-valid, fetched byte
//   dm_req/dm_we/dm_addr/dm_wdata    data access request
//   dm_wait/dm_done/dm_rdata         data stall, completion, loaded byte
//   mem_en/mem_we/mem_addr/mem_wdata RAM request (combinational)
//   mem_rdata                        RAM read data, one cycle after request
//
// Handshake: a side whose wait is high must hold req and its address/data
// stable; a request with wait low is accepted in that cycle and returns its
// valid/done exactly one cycle later.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = PKG_ADDR_W,
  parameter int DATA_W     = PKG_DATA_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_wait,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_wait,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_q, starve_d;
  ret_t                ret_q, ret_d;
  logic                gnt_fetch, gnt_data;

  // Grant decision. Data wins contention until fetch has been denied
  // STARVE_LIM times in a row; nothing is granted while in reset.
  always_comb begin
    gnt_data  = 1'b0;
    gnt_fetch = 1'b0;
    if (!rst) begin
      if (dm_req && (!if_req || (starve_q < STARVE_LIM))) begin
        gnt_data = 1'b1;
      end else if (if_req) begin
        gnt_fetch = 1'b1;
      end
    end
  end

  assign if_wait = if_req & gnt_data;
  assign dm_wait = dm_req & gnt_fetch;

  // RAM drive: the idle port presents zeros so the bus never floats on
  // stale requester values.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_data) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (gnt_fetch) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // Starvation counter: counts consecutive cycles fetch asked and lost.
  always_comb begin
    starve_d = starve_q;
    if (!if_req || gnt_fetch) begin
      starve_d = '0;
    end else if (gnt_data && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  // Return tag for next cycle's steering. Under reset no grant exists, so a
  // read requested in a reset cycle never produces a valid pulse.
  always_comb begin
    ret_d = '{tag: RTAG_NONE, wr: 1'b0};
    if (gnt_fetch) begin
      ret_d.tag = RTAG_FETCH;
    end else if (gnt_data) begin
      ret_d.tag = RTAG_DATA;
      ret_d.wr  = dm_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      ret_q    <= '{tag: RTAG_NONE, wr: 1'b0};
    end else begin
      starve_q <= starve_d;
      ret_q    <= ret_d;
    end
  end

  assign if_rvalid = (ret_q.tag == RTAG_FETCH);
  assign dm_done   = (ret_q.tag == RTAG_DATA);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = (dm_done && !ret_q.wr) ? mem_rdata : '0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single-port unified instruction/data RAM of the 8-bit pipelined processor between the fetch stage and the memory stage. Each cycle it grants the port to at most one requester, drives the RAM, and steers the returning read byte to the winner one cycle later. The losing side gets a wait signal that the hazard logic uses to hold the pipeline. A starvation counter guarantees forward progress for fetch.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- STARVE_MAX, 3, consecutive fetch denials before fetch is forced through (1..7)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch stage wants a byte
- if_addr  in  ADDR_W  fetch address (PC or PC+1 for 2-byte second byte)
- if_wait  out  1  fetch not granted this cycle; hazard logic holds F/D
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_W  fetched byte
- dm_req  in  1  memory stage access (load, store, push, pop, RET/RTI stack read)
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_wait  out  1  data access not granted this cycle; hazard logic holds M and earlier
- dm_done  out  1  data access completed (read data valid, or write committed)
- dm_rdata  out  DATA_W  loaded byte
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we=0

## Operation
- Grant decision combinational each cycle from if_req, dm_req, starvation counter:
  - only dm_req: grant data. Only if_req: grant fetch. Neither: mem_en=0.
  - both, starve_cnt < STARVE_MAX: grant data, if_wait=1, starve_cnt++.
  - both, starve_cnt == STARVE_MAX: grant fetch, dm_wait=1, starve_cnt cleared.
- starve_cnt cleared whenever fetch is granted or if_req=0; saturates at STARVE_MAX; 3 bits.
- Granted side drives mem_addr/mem_we/mem_wdata; fetch grant forces mem_we=0, mem_wdata=0.
- Idle port: mem_addr and mem_wdata hold 0.
- Return tag register rtag (NONE, FETCH, DATA) loaded on every edge with the current grant's type (reads and data writes; NONE if no grant).
- Cycle after grant: rtag=FETCH -> if_rvalid=1, if_rdata=mem_rdata; rtag=DATA -> dm_done=1, dm_rdata=mem_rdata for reads, 0 for writes.
- Outstanding reads never exceed one; a new grant in the return cycle is legal (back-to-back throughput 1 access/cycle).
- if_wait/dm_wait only asserted when the corresponding req is high.

## Timing
- Grant/wait outputs and mem_* combinational from inputs and state, same cycle as request.
- Read latency: grant cycle N -> data/valid in N+1. Write: committed at edge ending N, dm_done in N+1.
- Requester must hold req/addr/we/wdata stable while its wait is high.
- Reset: rtag=NONE, starve_cnt=0; if_rvalid=0, dm_done=0, if_rdata=0, dm_rdata=0 from the first cycle after reset. While rst=1 no grant: mem_en=0, if_wait=0, dm_wait=0.
- Reset mid-access: return of a read granted in the reset cycle is discarded; no valid pulse.
- Pipeline flush does not cancel an issued read; the requester discards it.

## Structure
- Shared processor package: ADDR_W/DATA_W defaults, rtag encoding (NONE=2'b00, FETCH=2'b01, DATA=2'b10).
- Single module; no sub-module. Starvation counter and rtag are the only state.

## Test plan
- if_req=1 alone, if_addr=0x10, RAM[0x10]=0xA5 -> cycle N mem_en=1 mem_addr=0x10, N+1 if_rvalid=1 if_rdata=0xA5, if_wait never high.
- Store dm_we=1 addr=0x80 wdata=0x3C while if_req=1 -> data granted, if_wait=1 in N, dm_done N+1; later read of 0x80 returns 0x3C.
- dm_req and if_req both held high 8 cycles, STARVE_MAX=3 -> grant pattern D,D,D,F,D,D,D,F; dm_wait high exactly on F cycles.
- Alternating fetch/data reads every cycle -> each return steered to correct side, no dropped or duplicated valid.
- rst asserted in the cycle a read is granted -> no if_rvalid/dm_done next cycle, all outputs at reset values, starve_cnt=0.
- Both reqs low -> mem_en=0, mem_addr=0, no valid pulses, waits low.
